// File: rtl/multiplier_iterative_if.sv
// Request/result bundle between a requester and the iterative multiplier.
interface multiplier_iterative_if #(
   parameter int WIDTH = 32
);
   logic               mult_begin;
   logic               is_signed;
   logic [WIDTH-1:0]   operand1;
   logic [WIDTH-1:0]   operand2;
   logic [2*WIDTH-1:0] product;
   logic               mult_end;
   logic               busy;

   modport master (
      output mult_begin, is_signed, operand1, operand2,
      input  product, mult_end, busy
   );

   modport slave (
      input  mult_begin, is_signed, operand1, operand2,
      output product, mult_end, busy
   );
endinterface

// File: rtl/multiplier_iterative.sv
// Iterative shift-add multiplier, STEP multiplier bits retired per clock.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module multiplier_iterative #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input logic                   clk,
   input logic                   resetn,
   multiplier_iterative_if.slave bus
);
   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e               state_q, state_d;
   logic                 sign_q, sign_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 mult_end_q, mult_end_d;

   logic [WIDTH-1:0]     abs1, abs2;
   logic [2*WIDTH-1:0]   pp, acc_sum;
   logic [WIDTH-1:0]     mplier_nx;
   logic                 last;

   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      product_d  = product_q;
      mult_end_d = mult_end_q;

      abs1 = (bus.is_signed && bus.operand1[WIDTH-1]) ? -bus.operand1 : bus.operand1;
      abs2 = (bus.is_signed && bus.operand2[WIDTH-1]) ? -bus.operand2 : bus.operand2;

      // multiplicand times the low STEP multiplier bits
      pp = '0;
      for (int j = 0; j < STEP; j++) begin
         if (mplier_q[j]) pp = pp + (mcand_q << j);
      end
      acc_sum   = acc_q + pp;
      mplier_nx = mplier_q >> STEP;

`ifdef MULT_EARLY_TERM_EN
      last = (mplier_nx == '0) || (cnt_q == CW'(N - 1));
`else
      last = (cnt_q == CW'(N - 1));
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.mult_begin) begin
               sign_d   = bus.is_signed &
                          (bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1]);
               mcand_d  = {{WIDTH{1'b0}}, abs1};
               mplier_d = abs2;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << STEP;
            mplier_d = mplier_nx;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
               product_d  = sign_q ? -acc_sum : acc_sum;
               mult_end_d = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (!bus.mult_begin) begin
               mult_end_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         sign_q     <= 1'b0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         product_q  <= '0;
         mult_end_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         product_q  <= product_d;
         mult_end_q <= mult_end_d;
      end
   end

   assign bus.product  = product_q;
   assign bus.mult_end = mult_end_q;
   assign bus.busy     = (state_q == BUSY);
endmodule
